// File: rtl/sr_input_conditioner_pkg.sv
// sr_input_conditioner_pkg: shared arbiter states, default parameters and counter sizing
package sr_input_conditioner_pkg;
  typedef enum logic [1:0] {IDLE, SET, CLR} state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sr_input_conditioner_debounce_channel.sv
// debounce_channel: synchronizes one raw button and accepts a change only after a stable run
module debounce_channel
  import sr_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic state
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic sample;
  assign sample = sync[SYNC_STAGES-1];
  // shift the raw button in, count differing samples, toggle on the last one; any bounce restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      state <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, btn});
      if (sample == state) cnt <= '0;
      else if (cnt == LAST) begin
        state <= ~state;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: debounced pushbuttons arbitrated into safe active-low S/R latch drives
module sr_input_conditioner
  import sr_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s,
  input  logic btn_r,
  input  logic Q_1,
  output logic S,
  output logic R,
  output logic Q_0,
  output logic conflict
);
  logic db_s, db_r, both_q;
  state_t state, state_n;
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_set (
    .clk(clk), .rst(rst), .btn(btn_s), .state(db_s)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk(clk), .rst(rst), .btn(btn_r), .state(db_r)
  );
  // first-pressed wins; a simultaneous press leaves the arbiter idle
  always_comb begin
    state_n = state == IDLE ? ((db_s && !db_r) ? SET : (db_r && !db_s) ? CLR : IDLE)
            : state == SET  ? (db_s ? SET : IDLE)
            : state == CLR  ? (db_r ? CLR : IDLE)
            : IDLE;
  end
  // S/R decoded from the next state into flops, so only one can ever be low
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      S <= 1'b1;
      R <= 1'b1;
      Q_0 <= 1'b0;
      both_q <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state <= state_n;
      S <= state_n != SET;
      R <= state_n != CLR;
      Q_0 <= Q_1;
      both_q <= db_s & db_r;
      conflict <= db_s & db_r & ~both_q;
    end
  end
endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb_sr_input_conditioner: directed scoreboard bench for the conditioner with short debounce
module tb_sr_input_conditioner;
  logic clk = 1'b0, rst = 1'b1, btn_s = 1'b0, btn_r = 1'b0, Q_1 = 1'b0;
  logic S, R, Q_0, conflict;
  bit tog = 1'b0;
  int total = 0, bad = 0;
  typedef struct {logic s; logic r; logic q0; logic c; bit cc;} exp_t;
  exp_t sb[$];

  sr_input_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .btn_s(btn_s), .btn_r(btn_r), .Q_1(Q_1),
    .S(S), .R(R), .Q_0(Q_0), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic step(input logic es, input logic er, input logic ec, input bit cc);
    exp_t e;
    sb.push_back('{es, er, rst ? 1'b0 : Q_1, ec, cc});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    assert (S === e.s) else begin bad++; $error("FAIL S obs=%b exp=%b t=%0t", S, e.s, $time); end
    total++;
    assert (R === e.r) else begin bad++; $error("FAIL R obs=%b exp=%b t=%0t", R, e.r, $time); end
    total++;
    assert (Q_0 === e.q0) else begin bad++; $error("FAIL Q_0 obs=%b exp=%b t=%0t", Q_0, e.q0, $time); end
    if (e.cc) begin
      total++;
      assert (conflict === e.c) else begin bad++; $error("FAIL conflict obs=%b exp=%b t=%0t", conflict, e.c, $time); end
    end
    Q_1 = tog ? ~Q_1 : 1'($urandom);
  endtask

  task automatic run(input int n, input logic es, input logic er, input bit cc);
    for (int i = 0; i < n; i++) step(es, er, 1'b0, cc);
  endtask

  initial begin
    run(3, 1, 1, 1);
    rst = 1'b0;
    run(2, 1, 1, 1);
    btn_s = 1'b1;
    run(6, 1, 1, 1);
    step(0, 1, 0, 1);
    run(3, 0, 1, 1);
    btn_s = 1'b0;
    run(6, 0, 1, 1);
    step(1, 1, 0, 1);
    run(2, 1, 1, 1);
    btn_s = 1'b1;
    run(3, 1, 1, 1);
    btn_s = 1'b0;
    run(1, 1, 1, 1);
    btn_s = 1'b1;
    run(6, 1, 1, 1);
    step(0, 1, 0, 1);
    btn_s = 1'b0;
    run(6, 0, 1, 1);
    step(1, 1, 0, 1);
    run(2, 1, 1, 1);
    btn_s = 1'b1;
    btn_r = 1'b1;
    run(6, 1, 1, 1);
    step(1, 1, 1, 1);
    run(4, 1, 1, 1);
    btn_s = 1'b0;
    btn_r = 1'b0;
    run(8, 1, 1, 1);
    btn_r = 1'b1;
    run(6, 1, 1, 1);
    step(1, 0, 0, 1);
    run(3, 1, 0, 1);
    btn_s = 1'b1;
    run(12, 1, 0, 0);
    btn_r = 1'b0;
    run(6, 1, 0, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    run(2, 0, 1, 1);
    btn_s = 1'b0;
    run(6, 0, 1, 1);
    step(1, 1, 0, 1);
    run(2, 1, 1, 1);
    btn_s = 1'b1;
    run(6, 1, 1, 1);
    step(0, 1, 0, 1);
    run(2, 0, 1, 1);
    rst = 1'b1;
    run(2, 1, 1, 1);
    rst = 1'b0;
    run(6, 1, 1, 1);
    step(0, 1, 0, 1);
    btn_s = 1'b0;
    run(6, 0, 1, 1);
    step(1, 1, 0, 1);
    tog = 1'b1;
    run(8, 1, 1, 1);
    rst = 1'b1;
    run(2, 1, 1, 1);
    rst = 1'b0;
    tog = 1'b0;
    run(2, 1, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sr_input_conditioner.md
SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-sample count before a button change is accepted (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop depth per button.
REQ-003 The block SHALL have port clk  input  1  the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port btn_s  input  1  raw asynchronous set pushbutton, active-high.
REQ-006 The block SHALL have port btn_r  input  1  raw asynchronous reset pushbutton, active-high.
REQ-007 The block SHALL have port Q_1  input  1  next-state output returned from the downstream active-low SR latch.
REQ-008 The block SHALL have port S  output  1  active-low set drive to the latch, registered.
REQ-009 The block SHALL have port R  output  1  active-low reset drive to the latch, registered.
REQ-010 The block SHALL have port Q_0  output  1  registered previous-state feedback to the latch.
REQ-011 The block SHALL have port conflict  output  1  one-cycle pulse when both debounced buttons are pressed together.

Function
REQ-012 Each button SHALL pass through SYNC_STAGES flops before any other use.
REQ-013 Per channel, a counter SHALL clear whenever the synchronized sample equals the debounced state, and SHALL increment otherwise.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the debounced state SHALL toggle and the counter SHALL clear on the same edge.
REQ-015 A bounce (sample returning to the debounced state) SHALL clear the counter, and no change SHALL be accepted.
REQ-016 The counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)), and the counter SHALL never wrap.
REQ-017 The arbiter SHALL be a three-state FSM: IDLE (S=1, R=1), SET (S=0, R=1) and CLR (S=1, R=0).
REQ-018 IDLE SHALL go to SET if only debounced set is pressed, and to CLR if only debounced reset is pressed.
REQ-019 If both debounced buttons become pressed on the same edge, IDLE SHALL stay in IDLE.
REQ-020 SET/CLR SHALL return to IDLE when their own button releases, regardless of the other button.
REQ-021 While in SET or CLR, a press of the other button SHALL be ignored, so first-pressed wins.
REQ-022 S and R SHALL never be low in the same cycle, so the latch's invalid state is unreachable.
REQ-023 conflict SHALL pulse for exactly one cycle on the edge where both debounced states first become pressed together, and SHALL not repeat until one is released.
REQ-024 Q_0 SHALL register Q_1 every cycle, giving a one-cycle feedback delay.
REQ-025 Press-to-output latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from a clean input edge to an S/R change.

Reset
REQ-026 While rst=1, on every clock edge: S=1, R=1, Q_0=0, conflict=0, FSM=IDLE, debounced states=0, counters=0, and synchronizers=0.
REQ-027 A reset asserted mid-press SHALL abort the press, so that after release of rst a still-held button needs a full debounce interval before S or R drops.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, SET, CLR) and the default DEBOUNCE_CYCLES/SYNC_STAGES constants.
REQ-029 The synchronizer plus debounce logic SHALL be one sub-module, debounce_channel, instantiated twice; the arbiter and Q_0 register SHALL be in the top level.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Clean press: btn_s 0->1 held -> S falls exactly 7 cycles later, and R stays 1.
REQ-031 Bounce: btn_s high for 3 cycles, low 1, then high -> no S change until 7 cycles after the final rising edge.
REQ-032 Simultaneous press: btn_s and btn_r rise on the same edge -> conflict pulses once, and S=R=1 throughout.
REQ-033 Priority: btn_r pressed, then btn_s 10 cycles later -> R=0 and S=1; release btn_r -> R=1 after 7 cycles, then FSM enters SET and S=0 the following cycle.
REQ-034 Reset mid-press: rst pulsed while S=0 with btn_s held -> S=1 during reset, and S falls 7 cycles after rst deasserts.
REQ-035 Feedback: Q_1 toggled each cycle -> Q_0 equals Q_1 delayed by one cycle, and Q_0=0 during reset.
